// File: rtl/fixed_power.sv
// Iterative unsigned Q10.10 exponentiation: out = base ^ n, with one multiply per cycle,
// floor truncation after each step and sticky saturation on overflow.
module fixed_power #(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [EXP_W-1:0]  in_data_2,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf
);

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   x_reg, x_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;
  logic [EXP_W-1:0]    cnt_reg, cnt_next;
  logic                ovf_reg, ovf_next;

  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] quot;
  logic                q_big;

  // Full-width product, then floor back to the Q format; any bit above DATA_W means overflow.
  assign prod  = {{DATA_W{1'b0}}, acc_reg} * {{DATA_W{1'b0}}, x_reg};
  assign quot  = prod >> FRAC_W;
  assign q_big = |quot[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          x_next     = in_data_1;
          acc_next   = ONE;
          cnt_next   = in_data_2;
          ovf_next   = 1'b0;
          state_next = (in_data_2 == '0) ? OUT : MUL;
        end
      end
      MUL: begin
        if (q_big || ovf_reg) begin
          acc_next = '1;
          ovf_next = 1'b1;
        end else begin
          acc_next = quot[DATA_W-1:0];
        end
        cnt_next = cnt_reg - EXP_W'(1);
        if (cnt_reg == EXP_W'(1)) begin
          state_next = OUT;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs come straight from registered state so they are glitch-free and zero outside OUT.
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == OUT);
  assign out_data  = out_valid ? acc_reg : '0;
  assign out_ovf   = out_valid & ovf_reg;

endmodule

// File: tb/tb_fixed_power.sv
// Self-checking bench for fixed_power: table-driven requests, a scoreboard queue of
// expected results, and hand-written sequences for busy-ignore and mid-operation reset.
module tb_fixed_power;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 10;
  localparam int EXP_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data_1;
  logic [EXP_W-1:0]  in_data_2;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;

  fixed_power #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] x;
    logic [EXP_W-1:0]  n;
    logic [DATA_W-1:0] exp_data;
    logic              exp_ovf;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ovf;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference arithmetic: floor after each multiply, sticky saturation.
  task automatic pow_model(input logic [DATA_W-1:0] x, input int n,
                           output logic [DATA_W-1:0] d, output logic o);
    longint unsigned acc, q;
    acc = 64'd1 << FRAC_W;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      q = (acc * longint'(x)) >> FRAC_W;
      if (o || q > 64'hFFFFF) begin
        acc = 64'hFFFFF;
        o = 1'b1;
      end else begin
        acc = q;
      end
    end
    d = acc[DATA_W-1:0];
  endtask

  // Scoreboard: pop on every out_valid; outside out_valid the outputs must be zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=0x%0h required=none", out_data);
        end else begin
          res_t r;
          r = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(r.data));
          check("out_ovf", 32'(out_ovf), 32'(r.ovf));
        end
      end else begin
        check("idle_out_zero", {11'd0, out_ovf, out_data}, 32'd0);
      end
    end
  end

  // Issue one request and verify busy profile and latency n+1.
  task automatic do_req(input logic [DATA_W-1:0] x, input logic [EXP_W-1:0] n,
                        input logic [DATA_W-1:0] ed, input logic eo);
    int k;
    res_t r;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data_1 = x; in_data_2 = n;
    r.data = ed; r.ovf = eo;
    exp_q.push_back(r);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data_1 = DATA_W'($urandom);
    in_data_2 = EXP_W'($urandom);
    k = 1;
    while (out_valid !== 1'b1 && k < 20) begin
      if (busy !== 1'b1) check("busy_during_op", 32'(busy), 32'd1);
      @(posedge clk); #1;
      k++;
    end
    check("latency", 32'(k), 32'(n) + 32'd1);
    check("busy_at_out", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("busy_after_out", 32'(busy), 32'd0);
    $display("req x=0x%05h n=%0d expect=0x%05h ovf=%0d latency=%0d", x, n, ed, eo, k);
  endtask

  initial begin
    logic [DATA_W-1:0] md;
    logic              mo;
    int                ov_cnt;

    vecs[0]  = '{20'h00800, 3'd3, 20'h02000, 1'b0};
    vecs[1]  = '{20'h12345, 3'd0, 20'h00400, 1'b0};
    vecs[2]  = '{20'h12345, 3'd1, 20'h12345, 1'b0};
    vecs[3]  = '{20'h005A8, 3'd2, 20'h007FF, 1'b0};
    vecs[4]  = '{20'h00200, 3'd7, 20'h00008, 1'b0};
    vecs[5]  = '{20'h00001, 3'd2, 20'h00000, 1'b0};
    vecs[6]  = '{20'h08000, 3'd2, 20'hFFFFF, 1'b1};
    vecs[7]  = '{20'h08000, 3'd7, 20'hFFFFF, 1'b1};
    vecs[8]  = '{20'h00000, 3'd0, 20'h00400, 1'b0};
    vecs[9]  = '{20'h00000, 3'd3, 20'h00000, 1'b0};
    vecs[10] = '{20'hFFFFF, 3'd1, 20'hFFFFF, 1'b0};
    vecs[11] = '{20'h00400, 3'd7, 20'h00400, 1'b0};
    vecs[12] = '{20'h01000, 3'd4, 20'h40000, 1'b0};
    vecs[13] = '{20'h01000, 3'd5, 20'hFFFFF, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out", {11'd0, out_ovf, out_data}, 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) do_req(vecs[i].x, vecs[i].n, vecs[i].exp_data, vecs[i].exp_ovf);

    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] rx;
      logic [EXP_W-1:0]  rn;
      rx = DATA_W'($urandom_range(0, 20'h01800));
      rn = EXP_W'($urandom_range(0, 7));
      pow_model(rx, int'(rn), md, mo);
      do_req(rx, rn, md, mo);
    end

    // Busy handling: requests in cycles 3 and 8 are ignored; cycle 9 is accepted.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd7;
    exp_q.push_back('{20'h20000, 1'b0});
    ov_cnt = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      in_valid = (c == 3 || c == 8 || c == 9);
      in_data_1 = (c == 9) ? 20'h00C00 : 20'h00400;
      in_data_2 = 3'd1;
      if (c == 9) exp_q.push_back('{20'h00C00, 1'b0});
      if (out_valid === 1'b1) ov_cnt++;
      if (c == 8)  check("busy_seq_valid_c8", 32'(out_valid), 32'd1);
      if (c == 9)  check("busy_seq_idle_c9", 32'(busy), 32'd0);
      if (c == 11) check("busy_seq_valid_c11", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    check("busy_seq_valid_count", 32'(ov_cnt), 32'd2);
    $display("busy-ignore sequence done out_valid_count=%0d", ov_cnt);

    // Reset mid-operation: start n=5, reset in cycle 3, expect silence afterwards.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data_1 = 20'h00800; in_data_2 = 3'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_out", {10'd0, out_valid, out_ovf, out_data}, 32'd0);
    ov_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) ov_cnt++;
    end
    check("rst_mid_silent", 32'(ov_cnt), 32'd0);
    $display("reset-abort sequence done activity=%0d", ov_cnt);
    do_req(20'h00600, 3'd2, 20'h00900, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
